// File: rtl/i2c_byte_master.sv
// Byte-level I2C master PHY: START/STOP/WRITE/READ commands to SCL/SDA waveforms.
// Open-drain SDA, no clock stretching, all bus changes on quarter-period boundaries.
module i2c_byte_master #(
  parameter int unsigned CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       rst,
  inout  logic       sda,
  output logic       scl,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] data_in,
  input  logic       write,
  input  logic       read,
  input  logic       ack_read,
  output logic       ack,
  output logic [7:0] data_out,
  output logic       out_valid,
  output logic       busy
);

  localparam int unsigned QW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] QLAST = QW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, START, STOP, WBIT, WACK, RBIT, RACK, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [QW-1:0]   qcnt_q, qcnt_d;
  logic [1:0]      phase_q, phase_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            ackrd_q, ackrd_d;
  logic            ack_smp_q, ack_smp_d;
  logic            ack_q, ack_d;
  logic [7:0]      data_out_q, data_out_d;
  logic            out_valid_q, out_valid_d;
  logic            scl_q, scl_d;
  logic            sda_oe_q, sda_oe_d;

  logic            sda_in;
  logic            tick;
  logic [1:0]      last_ph;
  logic            scl_pulse;

  assign sda_in = sda;
  assign tick    = (qcnt_q == QLAST);
  assign last_ph = (state_q == STOP) ? 2'd2 : 2'd3;

  always_comb begin
    state_d     = state_q;
    qcnt_d      = qcnt_q;
    phase_d     = phase_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    ackrd_d     = ackrd_q;
    ack_smp_d   = ack_smp_q;
    ack_d       = ack_q;
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        qcnt_d  = '0;
        phase_d = '0;
        if (start) begin
          state_d = START;
        end else if (stop) begin
          state_d = STOP;
        end else if (write) begin
          state_d  = WBIT;
          shreg_d  = data_in;
          bitcnt_d = '0;
        end else if (read) begin
          state_d  = RBIT;
          ackrd_d  = ack_read;
          bitcnt_d = '0;
        end
      end
      DONE: state_d = IDLE;
      default: begin
        qcnt_d = tick ? '0 : qcnt_q + 1'b1;
        if (tick) begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd1) begin
            if (state_q == WACK) ack_smp_d = ~sda_in;
            if (state_q == RBIT) shreg_d   = {shreg_q[6:0], sda_in};
          end
          if (phase_q == last_ph) begin
            phase_d = '0;
            case (state_q)
              WBIT: begin
                shreg_d  = {shreg_q[6:0], 1'b0};
                bitcnt_d = bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) state_d = WACK;
              end
              RBIT: begin
                bitcnt_d = bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) state_d = RACK;
              end
              WACK: begin
                ack_d   = ack_smp_q;
                state_d = DONE;
              end
              RACK: begin
                data_out_d  = shreg_q;
                out_valid_d = 1'b1;
                state_d     = DONE;
              end
              default: state_d = DONE;
            endcase
          end
        end
      end
    endcase
  end

  // Bus levels are derived from the next state/phase so the registered pins
  // change exactly on the quarter boundary; IDLE/DONE hold the last level.
  assign scl_pulse = (phase_d == 2'd1) || (phase_d == 2'd2);

  always_comb begin
    scl_d    = scl_q;
    sda_oe_d = sda_oe_q;
    case (state_d)
      START: begin
        scl_d    = scl_pulse;
        sda_oe_d = phase_d[1];
      end
      STOP: begin
        scl_d    = (phase_d != 2'd0);
        sda_oe_d = (phase_d != 2'd2);
      end
      WBIT: begin
        scl_d    = scl_pulse;
        sda_oe_d = ~shreg_d[7];
      end
      WACK, RBIT: begin
        scl_d    = scl_pulse;
        sda_oe_d = 1'b0;
      end
      RACK: begin
        scl_d    = scl_pulse;
        sda_oe_d = ackrd_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      qcnt_q      <= '0;
      phase_q     <= '0;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      ackrd_q     <= 1'b0;
      ack_smp_q   <= 1'b0;
      ack_q       <= 1'b0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      scl_q       <= 1'b1;
      sda_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      qcnt_q      <= qcnt_d;
      phase_q     <= phase_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      ackrd_q     <= ackrd_d;
      ack_smp_q   <= ack_smp_d;
      ack_q       <= ack_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      scl_q       <= scl_d;
      sda_oe_q    <= sda_oe_d;
    end
  end

  assign sda       = sda_oe_q ? 1'b0 : 1'bz;
  assign scl       = scl_q;
  assign busy      = (state_q != IDLE);
  assign ack       = ack_q;
  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Directed bench for i2c_byte_master with a pulled-up slave BFM and a read-data scoreboard.
module tb_i2c_byte_master;

  localparam int unsigned DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  wire        sda;
  logic       scl;
  logic       start = 1'b0, stop = 1'b0, write = 1'b0, read = 1'b0, ack_read = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       ack, out_valid, busy;
  logic [7:0] data_out;

  int nchk = 0;
  int nerr = 0;

  // slave BFM state
  logic       bfm_low = 1'b0;
  int         mode = 0;        // 0 idle, 1 write-target, 2 read-source
  logic       ack_en = 1'b0;
  logic [7:0] rd_byte = 8'h00;
  int         nfall = 0;
  logic [8:0] rx_bits = '0;
  int         start_seen = 0;
  int         stop_seen = 0;
  int         nvalid = 0;
  logic [7:0] exp_q[$];

  pullup (sda);
  assign sda = bfm_low ? 1'b0 : 1'bz;

  i2c_byte_master #(.CLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .sda(sda), .scl(scl),
    .start(start), .stop(stop), .data_in(data_in), .write(write), .read(read),
    .ack_read(ack_read), .ack(ack), .data_out(data_out), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge scl) begin
    nfall++;
    if (mode == 1) begin
      if (nfall == 8) bfm_low = ack_en;
      else if (nfall == 9) bfm_low = 1'b0;
    end else if (mode == 2) begin
      if (nfall < 8) bfm_low = ~rd_byte[7 - nfall];
      else bfm_low = 1'b0;
    end
  end

  always @(posedge scl) rx_bits = {rx_bits[7:0], sda};
  always @(negedge sda) if (scl === 1'b1) start_seen++;
  always @(posedge sda) if (scl === 1'b1) stop_seen++;

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      nvalid++;
      if (exp_q.size() == 0) check("unexpected_out_valid", 32'(data_out), 32'hFFFF_FFFF);
      else check("data_out", 32'(data_out), 32'(exp_q.pop_front()));
    end
  end

  task automatic issue(input logic s, input logic p, input logic w, input logic r,
                       input logic [7:0] d, input logic ar, input int m,
                       input logic ae, input logic [7:0] rb);
    @(negedge clk);
    mode = m; ack_en = ae; rd_byte = rb; nfall = 0; rx_bits = '0;
    start_seen = 0; stop_seen = 0;
    bfm_low = (m == 2) ? ~rb[7] : 1'b0;
    start = s; stop = p; write = w; read = r; data_in = d; ack_read = ar;
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0; write = 1'b0; read = 1'b0;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (1) begin
      @(negedge clk);
      if (busy === 1'b0) break;
      cnt++;
      if (cnt > 2000) begin
        check("busy_timeout", 32'(cnt), 32'd0);
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int nv0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("rst_scl", 32'(scl), 32'd1);
    check("rst_sda", 32'(sda), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);

    issue(1, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    wait_idle(lat);
    check("start_latency", 32'(lat), 32'(4*DIV+1));
    check("start_cond", 32'(start_seen), 32'd1);
    check("start_scl_low", 32'(scl), 32'd0);
    check("start_sda_low", 32'(sda), 32'd0);

    issue(0, 0, 1, 0, 8'hB8, 0, 1, 1, 8'h00);
    wait_idle(lat);
    check("wr_ack_latency", 32'(lat), 32'(36*DIV+1));
    check("wr_ack_bits", 32'(rx_bits), 32'({8'hB8, 1'b0}));
    check("wr_ack", 32'(ack), 32'd1);

    issue(0, 0, 1, 0, 8'hB8, 0, 1, 0, 8'h00);
    wait_idle(lat);
    check("wr_nack_latency", 32'(lat), 32'(36*DIV+1));
    check("wr_nack_bits", 32'(rx_bits), 32'({8'hB8, 1'b1}));
    check("wr_nack", 32'(ack), 32'd0);

    nv0 = nvalid;
    exp_q.push_back(8'h5A);
    issue(0, 0, 0, 1, 8'h00, 0, 2, 0, 8'h5A);
    wait_idle(lat);
    check("rd_latency", 32'(lat), 32'(36*DIV+1));
    check("rd_valid_pulses", 32'(nvalid - nv0), 32'd1);
    check("rd_nak_bits", 32'(rx_bits), 32'({8'h5A, 1'b1}));
    check("rd_hold", 32'(data_out), 32'h5A);

    nv0 = nvalid;
    exp_q.push_back(8'hC3);
    issue(0, 0, 0, 1, 8'h00, 1, 2, 0, 8'hC3);
    wait_idle(lat);
    check("rd2_valid_pulses", 32'(nvalid - nv0), 32'd1);
    check("rd2_ack_bits", 32'(rx_bits), 32'({8'hC3, 1'b0}));

    issue(0, 1, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    wait_idle(lat);
    check("stop_latency", 32'(lat), 32'(3*DIV+1));
    check("stop_cond", 32'(stop_seen), 32'd1);
    check("stop_scl", 32'(scl), 32'd1);
    check("stop_sda", 32'(sda), 32'd1);

    issue(1, 0, 1, 0, 8'h00, 0, 0, 0, 8'h00);
    @(negedge clk);
    write = 1'b1; data_in = 8'hFF;
    @(posedge clk);
    #1 write = 1'b0;
    wait_idle(lat);
    check("prio_start_latency", 32'(lat), 32'(4*DIV));
    repeat (3) @(negedge clk);
    check("ignored_busy", 32'(busy), 32'd0);
    check("ignored_scl", 32'(scl), 32'd0);

    nv0 = nvalid;
    issue(0, 0, 0, 1, 8'h00, 1, 2, 0, 8'hA5);
    repeat (60) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; mode = 0; bfm_low = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_scl", 32'(scl), 32'd1);
    check("midrst_sda", 32'(sda), 32'd1);
    check("midrst_data_out", 32'(data_out), 32'd0);
    repeat (200) @(negedge clk);
    check("midrst_no_valid", 32'(nvalid - nv0), 32'd0);
    check("midrst_still_idle", 32'(busy), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
